// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write, read, reserve/flush and busy-vector signals of the multi-port register file.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRP  = 4,
    parameter int NWP  = 2
);
    logic [NWP-1:0]      i_write_flag;
    logic [NWP*AW-1:0]   i_write_addr;
    logic [NWP*XLEN-1:0] i_write_data;
    logic [NRP-1:0]      i_read_flag;
    logic [NRP*AW-1:0]   i_read_addr;
    logic [NRP*XLEN-1:0] o_read_data;
    logic [NRP-1:0]      o_read_busy;
    logic                i_rsv_flag;
    logic [AW-1:0]       i_rsv_addr;
    logic                i_flush;
    logic [NREG-1:0]     o_busy_vec;
    modport slave (
        input  i_write_flag, i_write_addr, i_write_data, i_read_flag, i_read_addr,
        input  i_rsv_flag, i_rsv_addr, i_flush,
        output o_read_data, o_read_busy, o_busy_vec
    );
    modport master (
        output i_write_flag, i_write_addr, i_write_data, i_read_flag, i_read_addr,
        output i_rsv_flag, i_rsv_addr, i_flush,
        input  o_read_data, o_read_busy, o_busy_vec
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with per-register busy scoreboard, x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRP  = 4,
    parameter int NWP  = 2
) (
    input logic clk,
    input logic rst,
    regfile_mp_if.slave bus
);
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy, busy_nxt;
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;

    // Priority: write clears, then reserve sets, then flush clears everything.
    always_comb begin
        busy_nxt = busy;
        for (int k = 0; k < NWP; k++)
            if (bus.i_write_flag[k]) busy_nxt[bus.i_write_addr[k*AW +: AW]] = 1'b0;
        if (bus.i_rsv_flag) busy_nxt[bus.i_rsv_addr] = 1'b1;
        busy_nxt = bus.i_flush ? '0 : busy_nxt;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            for (int k = 0; k < NWP; k++)
                if (bus.i_write_flag[k] && bus.i_write_addr[k*AW +: AW] != '0)
                    regs[bus.i_write_addr[k*AW +: AW]] <= bus.i_write_data[k*XLEN +: XLEN];
            busy <= busy_nxt;
        end
    end

    always_comb begin
        bus.o_read_data = '0;
        bus.o_read_busy = '0;
        ra = '0;
        rd = '0;
        rb = 1'b0;
        for (int j = 0; j < NRP; j++) begin
            ra = bus.i_read_addr[j*AW +: AW];
            rd = regs[ra];
            rb = busy[ra];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NWP; k++)
                if (bus.i_write_flag[k] && bus.i_write_addr[k*AW +: AW] == ra && ra != '0) begin
                    rd = bus.i_write_data[k*XLEN +: XLEN];
                    rb = 1'b0;
                end
`endif
            bus.o_read_data[j*XLEN +: XLEN] = (rst && bus.i_read_flag[j]) ? rd : '0;
            bus.o_read_busy[j] = rst && bus.i_read_flag[j] && rb;
        end
    end

    assign bus.o_busy_vec = busy;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plan steps plus random traffic checked against an array/bit-vector model.
module tb_regfile_mp;
    localparam int XLEN = 32, NREG = 32, AW = 5, NRP = 4, NWP = 2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP), .NWP(NWP)) bus ();
    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRP(NRP), .NWP(NWP)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    logic [XLEN-1:0] m_regs [NREG];
    logic [NREG-1:0] m_busy;
    logic [NWP-1:0]  wf;
    logic [AW-1:0]   wa [NWP];
    logic [XLEN-1:0] wd [NWP];
    logic [NRP-1:0]  rf;
    logic [AW-1:0]   ra [NRP];
    logic            rsv, fl;
    logic [AW-1:0]   rsva;
    int tests = 0, fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wf = '0; rf = '0; rsv = 1'b0; fl = 1'b0; rsva = '0;
        for (int k = 0; k < NWP; k++) begin wa[k] = '0; wd[k] = '0; end
        for (int j = 0; j < NRP; j++) ra[j] = '0;
    endtask

    task automatic drive();
        bus.i_write_flag = wf;
        bus.i_read_flag  = rf;
        bus.i_rsv_flag   = rsv;
        bus.i_rsv_addr   = rsva;
        bus.i_flush      = fl;
        for (int k = 0; k < NWP; k++) begin
            bus.i_write_addr[k*AW +: AW]   = wa[k];
            bus.i_write_data[k*XLEN +: XLEN] = wd[k];
        end
        for (int j = 0; j < NRP; j++) bus.i_read_addr[j*AW +: AW] = ra[j];
    endtask

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
        m_busy = '0;
    endtask

    // One clock: check combinational reads against the model, clock, update model, check busy vector.
    task automatic step();
        logic [XLEN-1:0] ed;
        logic eb;
        drive();
        #2;
        for (int j = 0; j < NRP; j++) begin
            ed = (rst && rf[j]) ? m_regs[ra[j]] : '0;
            eb = rst && rf[j] && m_busy[ra[j]];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NWP; k++)
                if (rst && rf[j] && wf[k] && wa[k] == ra[j] && ra[j] != 0) begin
                    ed = wd[k];
                    eb = 1'b0;
                end
`endif
            chk($sformatf("rd_data[%0d]", j), 64'(bus.o_read_data[j*XLEN +: XLEN]), 64'(ed));
            chk($sformatf("rd_busy[%0d]", j), 64'(bus.o_read_busy[j]), 64'(eb));
        end
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < NWP; k++)
                if (wf[k] && wa[k] != 0) begin
                    m_regs[wa[k]] = wd[k];
                    m_busy[wa[k]] = 1'b0;
                end
            if (rsv && rsva != 0) m_busy[rsva] = 1'b1;
            if (fl) m_busy = '0;
        end
        #1;
        chk("busy_vec", 64'(bus.o_busy_vec), 64'(m_busy));
    endtask

    task automatic peek(input string tag, input int p, input logic [AW-1:0] a,
                        input logic [XLEN-1:0] ed, input logic eb);
        rf[p] = 1'b1;
        ra[p] = a;
        drive();
        #1;
        chk({tag, "_data"}, 64'(bus.o_read_data[p*XLEN +: XLEN]), 64'(ed));
        chk({tag, "_busy"}, 64'(bus.o_read_busy[p]), 64'(eb));
    endtask

    task automatic rand_step();
        idle();
        for (int k = 0; k < NWP; k++) begin
            wf[k] = 1'($urandom_range(0, 1));
            wa[k] = AW'($urandom_range(0, NREG - 1));
            wd[k] = $urandom;
        end
        for (int j = 0; j < NRP; j++) begin
            rf[j] = ($urandom_range(0, 3) != 0);
            ra[j] = AW'($urandom_range(0, NREG - 1));
        end
        rsv  = 1'($urandom_range(0, 1));
        rsva = AW'($urandom_range(0, NREG - 1));
        fl   = ($urandom_range(0, 15) == 0);
        step();
    endtask

    initial begin
        model_clear();
        idle();
        drive();
        // Held in reset: writes to x5 must not land, reads return zero.
        wf[0] = 1'b1; wa[0] = 5; wd[0] = 32'h1234_5678; rf[0] = 1'b1; ra[0] = 5;
        rsv = 1'b1; rsva = 5;
        step();
        step();
        rst = 1'b1;
        idle(); wf[0] = 1'b1; wa[0] = 5; wd[0] = 32'hDEAD_BEEF;
        step();
        idle(); peek("x5_after_write", 0, 5, 32'hDEAD_BEEF, 1'b0);
        step();
        // x0 protection
        idle(); wf[1] = 1'b1; wa[1] = 0; wd[1] = 32'hFFFF_FFFF; rsv = 1'b1; rsva = 0;
        step();
        idle(); peek("x0_read", 1, 0, 32'h0, 1'b0);
        chk("x0_busy", 64'(bus.o_busy_vec[0]), 64'h0);
        // Write port conflict
        idle(); wf = 2'b11; wa[0] = 7; wd[0] = 32'h11; wa[1] = 7; wd[1] = 32'h22;
        step();
        idle(); peek("conflict_x7", 3, 7, 32'h22, 1'b0);
        // Scoreboard set/clear and reserve-wins
        idle(); rsv = 1'b1; rsva = 3;
        step();
        chk("rsv_x3", 64'(bus.o_busy_vec[3]), 64'h1);
        idle(); wf[0] = 1'b1; wa[0] = 3; wd[0] = 32'h5;
        step();
        chk("wr_clr_x3", 64'(bus.o_busy_vec[3]), 64'h0);
        idle(); rsv = 1'b1; rsva = 3; wf[1] = 1'b1; wa[1] = 3; wd[1] = 32'h77;
        step();
        chk("rsv_wins_x3", 64'(bus.o_busy_vec[3]), 64'h1);
        idle(); peek("x3_new", 0, 3, 32'h77, 1'b1);
        // Flush overrides reserve; same-cycle write still commits
        idle(); wf[0] = 1'b1; wa[0] = 3; wd[0] = 32'h78; rsv = 1'b1; rsva = 1;
        step();
        idle(); rsv = 1'b1; rsva = 2;
        step();
        idle(); rsv = 1'b1; rsva = 4;
        step();
        chk("pre_flush", 64'(bus.o_busy_vec), 64'h16);
        idle(); fl = 1'b1; rsv = 1'b1; rsva = 6; wf[0] = 1'b1; wa[0] = 10; wd[0] = 32'hCAFE;
        step();
        chk("flush_vec", 64'(bus.o_busy_vec), 64'h0);
        idle(); peek("flush_write", 2, 10, 32'hCAFE, 1'b0);
        // Same-cycle write and read of a busy register
        idle(); rsv = 1'b1; rsva = 9;
        step();
        idle(); wf[1] = 1'b1; wa[1] = 9; wd[1] = 32'hA5A5_A5A5;
`ifdef REGFILE_BYPASS_EN
        peek("bypass_x9", 2, 9, 32'hA5A5_A5A5, 1'b0);
`else
        peek("nobypass_x9", 2, 9, 32'h0, 1'b1);
`endif
        step();
        idle(); peek("x9_after", 2, 9, 32'hA5A5_A5A5, 1'b0);
        for (int n = 0; n < 400; n++) rand_step();
        // Asynchronous reset mid-operation, away from any clock edge
        idle(); rf = '1; ra[0] = 3; ra[1] = 9; ra[2] = 10; ra[3] = 5;
        drive();
        rst = 1'b0;
        #1;
        chk("async_rst_busy", 64'(bus.o_busy_vec), 64'h0);
        chk("async_rst_rd", 64'(bus.o_read_data), 64'h0);
        model_clear();
        step();
        rst = 1'b1;
        for (int n = 0; n < 150; n++) rand_step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
